ce_sequencer: RTL and testbench
===============================

# ce_sequencer

Clock-enable and reset sequencer that runs directly downstream of the system PLL. It runs in the 56 MHz system clock domain and consumes the PLL `locked` flag. It produces the one-cycle clock-enable strobes (28/14/7/3.5 MHz and CPU phase enables with turbo and wait-hold) used by the ULA, CPU and audio blocks. It also produces a system reset that is released only after the PLL lock has been stable for a programmable time.

## Interface
- `LOCK_WAIT`, default 1024: number of consecutive `clk_sys` cycles with synchronised lock required before `sys_reset` is released; legal range 1..65535.
- `clk_sys` in 1: 56 MHz system clock (PLL 56 MHz output); the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `pll_locked` in 1: PLL lock flag, asynchronous to `clk_sys`.
- `turbo` in 2: CPU speed select. 0 = 3.5 MHz, 1 = 7 MHz, 2 = 14 MHz, 3 = 28 MHz.
- `cpu_hold` in 1: wait/contention request; suppresses CPU enable pairs.
- `sys_reset` out 1: active-high synchronous system reset.
- `ce_28m`, `ce_14m`, `ce_7m`, `ce_3m5` out 1 each: one-cycle enables at 28/14/7/3.5 MHz.
- `ce_cpu_p`, `ce_cpu_n` out 1 each: CPU clock rising/falling phase enables.

## Operation
- Lock synchroniser: 2-flop chain `pll_locked` -> `locked_s`.
- Divider: 4-bit `div`.
  - Held at 0 while `locked_s`=0.
  - Increments mod 16 every cycle while `locked_s`=1.
- Decode of registered `div` (value in cycle k drives outputs in cycle k+1):
  - `ce_28m` when div[0]=0.
  - `ce_14m` when div[1:0]=0.
  - `ce_7m` when div[2:0]=0.
  - `ce_3m5` when div=0.
- Turbo register `turbo_r`:
  - Loads `turbo` every cycle while `locked_s`=0.
  - Otherwise loads only when div=15, so speed changes take effect at a 3.5 MHz boundary and never produce a short CPU phase.
- CPU slots per `turbo_r`:
  - 0: p-slot div=0, n-slot div=8.
  - 1: p-slot div[2:0]=0, n-slot div[2:0]=4.
  - 2: p-slot div[1:0]=0, n-slot div[1:0]=2.
  - 3: p-slot div[0]=0, n-slot div[0]=1.
- Hold logic:
  - p fires = p-slot & ~`cpu_hold` (cpu_hold sampled in the same cycle as div). A fire sets flag `half`.
  - n fires = n-slot & `half`; the fire clears `half`.
  - A held p-slot therefore also suppresses its n. `ce_cpu_p`/`ce_cpu_n` strictly alternate, starting with p.
- Reset sequencer, 16-bit wait counter `wcnt`:
  - Cleared while `locked_s`=0.
  - Increments while `locked_s`=1 and `wcnt`<LOCK_WAIT.
  - `sys_reset` = (`wcnt` != LOCK_WAIT), registered.
- Lock loss: `locked_s` falling clears `div`, `wcnt` and `half`. On the next edge `sys_reset`=1 and all ce outputs are 0.
- `cpu_hold` is ignored while `locked_s`=0.
- Enables run during `sys_reset` once `locked_s`=1, so downstream blocks clock their resets in.

## Timing
- `rst_n` low, asynchronous: synchroniser=0, `div`=0, `wcnt`=0, `half`=0, `turbo_r`=0, `sys_reset`=1, all ce outputs=0.
- Lock latency:
  - `pll_locked` rising before edge E0 gives `locked_s`=1 after edge E1.
  - The first cycle with `locked_s`=1 has div=0, so after the following edge all of `ce_28m`, `ce_14m`, `ce_7m`, `ce_3m5`, `ce_cpu_p` assert together. This is the common-zero alignment.
- `sys_reset` deasserts exactly LOCK_WAIT+1 edges after the first edge that sees `locked_s`=1.
- Lock loss: `sys_reset` rises 3 edges after `pll_locked` falls (2 synchroniser + 1 output). A lock glitch shorter than one cycle is not guaranteed to be seen.
- Every ce output is high for exactly one cycle. Periods: 2/4/8/16 cycles; CPU p-p period 16/8/4/2 cycles.
- A `turbo` change at div=k≠15 takes effect in the first p-slot at div=0 following the next div=15.

## Test plan
- Power-up (LOCK_WAIT=16): `rst_n` low 5 cycles, `pll_locked`=1 from start. Required:
  - `sys_reset` falls on the 17th edge after `locked_s` rises.
  - First ce pulses are coincident.
  - `ce_3m5` period is 16, `ce_7m` is 8, `ce_14m` is 4, `ce_28m` is 2.
- Turbo sweep: step `turbo` 0->1->2->3, changing mid-period (div=5). Required:
  - `ce_cpu_p` period 16/8/4/2 with the n-slot at half period.
  - The new rate starts only at the p-slot after div=15.
  - No p-p gap is shorter than the new period.
- Hold: turbo=0, `cpu_hold`=1 for 20 cycles covering one div=0. Required: that p and its n at div=8 are both missing; the next p at div=0 fires normally; p/n strictly alternate.
- Hold, turbo=3: `cpu_hold` high on one p-slot only. Required: exactly one p and one n are dropped; all other slots fire.
- Lock loss mid-run: drop `pll_locked` for 10 cycles at div=7. Required:
  - `sys_reset`=1 three edges later; all ce outputs 0 until relock.
  - After relock, alignment restarts at div=0 and `sys_reset` is re-released after a full LOCK_WAIT.
- Async reset mid-run: assert `rst_n` low between edges during `sys_reset`=0. Required: all outputs reach their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ce_sequencer.sv
// Clock-enable and reset sequencer for the 56 MHz system domain: derives the
// 28/14/7/3.5 MHz and CPU phase strobes and holds sys_reset until PLL lock is stable.
module ce_sequencer #(
  parameter int unsigned LOCK_WAIT = 1024
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic [1:0] turbo,
  input  logic       cpu_hold,
  output logic       sys_reset,
  output logic       ce_28m,
  output logic       ce_14m,
  output logic       ce_7m,
  output logic       ce_3m5,
  output logic       ce_cpu_p,
  output logic       ce_cpu_n
);

  localparam logic [15:0] LockWait16 = 16'(LOCK_WAIT);

  logic        r_sync1;
  logic        r_locked_s;
  logic [3:0]  r_div;
  logic [1:0]  r_turbo;
  logic        r_half;
  logic [15:0] r_wcnt;
  logic        r_sys_reset;
  logic        r_ce_28m;
  logic        r_ce_14m;
  logic        r_ce_7m;
  logic        r_ce_3m5;
  logic        r_ce_cpu_p;
  logic        r_ce_cpu_n;

  logic        w_p_slot;
  logic        w_n_slot;
  logic        w_p_fire;
  logic        w_n_fire;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= 1'b0;
      r_locked_s <= 1'b0;
    end else begin
      r_sync1    <= pll_locked;
      r_locked_s <= r_sync1;
    end
  end

  // Divider and turbo register: turbo only changes at the 3.5 MHz wrap so a CPU phase is never cut short.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_div   <= 4'd0;
      r_turbo <= 2'd0;
    end else if (!r_locked_s) begin
      r_div   <= 4'd0;
      r_turbo <= turbo;
    end else begin
      r_div <= r_div + 4'd1;
      if (r_div == 4'd15) begin
        r_turbo <= turbo;
      end
    end
  end

  always_comb begin
    w_p_slot = 1'b0;
    w_n_slot = 1'b0;
    case (r_turbo)
      2'd0: begin
        w_p_slot = (r_div == 4'd0);
        w_n_slot = (r_div == 4'd8);
      end
      2'd1: begin
        w_p_slot = (r_div[2:0] == 3'd0);
        w_n_slot = (r_div[2:0] == 3'd4);
      end
      2'd2: begin
        w_p_slot = (r_div[1:0] == 2'd0);
        w_n_slot = (r_div[1:0] == 2'd2);
      end
      default: begin
        w_p_slot = ~r_div[0];
        w_n_slot = r_div[0];
      end
    endcase
    w_p_fire = r_locked_s & w_p_slot & ~cpu_hold;
    w_n_fire = r_locked_s & w_n_slot & r_half;
  end

  // half remembers an issued p so a held p-slot also swallows its n.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_half <= 1'b0;
    end else if (!r_locked_s) begin
      r_half <= 1'b0;
    end else if (w_p_fire) begin
      r_half <= 1'b1;
    end else if (w_n_fire) begin
      r_half <= 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_wcnt      <= 16'd0;
      r_sys_reset <= 1'b1;
    end else begin
      if (!r_locked_s) begin
        r_wcnt <= 16'd0;
      end else if (r_wcnt < LockWait16) begin
        r_wcnt <= r_wcnt + 16'd1;
      end
      r_sys_reset <= ~r_locked_s | (r_wcnt != LockWait16);
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_ce_28m   <= 1'b0;
      r_ce_14m   <= 1'b0;
      r_ce_7m    <= 1'b0;
      r_ce_3m5   <= 1'b0;
      r_ce_cpu_p <= 1'b0;
      r_ce_cpu_n <= 1'b0;
    end else begin
      r_ce_28m   <= r_locked_s & ~r_div[0];
      r_ce_14m   <= r_locked_s & (r_div[1:0] == 2'd0);
      r_ce_7m    <= r_locked_s & (r_div[2:0] == 3'd0);
      r_ce_3m5   <= r_locked_s & (r_div == 4'd0);
      r_ce_cpu_p <= w_p_fire;
      r_ce_cpu_n <= w_n_fire;
    end
  end

  assign sys_reset = r_sys_reset;
  assign ce_28m    = r_ce_28m;
  assign ce_14m    = r_ce_14m;
  assign ce_7m     = r_ce_7m;
  assign ce_3m5    = r_ce_3m5;
  assign ce_cpu_p  = r_ce_cpu_p;
  assign ce_cpu_n  = r_ce_cpu_n;

endmodule

// File: tb/tb_ce_sequencer.sv
// Scoreboard bench for ce_sequencer: expected strobe cycles are queued as stimulus
// is issued and a monitor thread checks every strobe and sys_reset transition.
module tb_ce_sequencer;

  localparam int LW = 16;

  logic       clk_sys = 1'b0;
  logic       rst_n = 1'b1;
  logic       pll_locked = 1'b1;
  logic [1:0] turbo = 2'd0;
  logic       cpu_hold = 1'b0;
  logic       sys_reset;
  logic       ce_28m;
  logic       ce_14m;
  logic       ce_7m;
  logic       ce_3m5;
  logic       ce_cpu_p;
  logic       ce_cpu_n;

  ce_sequencer #(.LOCK_WAIT(LW)) dut (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .pll_locked(pll_locked),
    .turbo     (turbo),
    .cpu_hold  (cpu_hold),
    .sys_reset (sys_reset),
    .ce_28m    (ce_28m),
    .ce_14m    (ce_14m),
    .ce_7m     (ce_7m),
    .ce_3m5    (ce_3m5),
    .ce_cpu_p  (ce_cpu_p),
    .ce_cpu_n  (ce_cpu_n)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  typedef struct {
    int   c;
    logic v;
  } rstEv_t;

  int     total = 0;
  int     bad = 0;
  bit     monOn = 1'b1;
  int     qC28[$];
  int     qC14[$];
  int     qC7[$];
  int     qC35[$];
  int     qP[$];
  int     qN[$];
  rstEv_t qRst[$];
  string  names[6] = '{"ce_28m", "ce_14m", "ce_7m", "ce_3m5", "ce_cpu_p", "ce_cpu_n"};

  function automatic int qSize(input int s);
    case (s)
      0: return qC28.size();
      1: return qC14.size();
      2: return qC7.size();
      3: return qC35.size();
      4: return qP.size();
      default: return qN.size();
    endcase
  endfunction

  function automatic int qFront(input int s);
    case (s)
      0: return qC28[0];
      1: return qC14[0];
      2: return qC7[0];
      3: return qC35[0];
      4: return qP[0];
      default: return qN[0];
    endcase
  endfunction

  function automatic void qPop(input int s);
    case (s)
      0: void'(qC28.pop_front());
      1: void'(qC14.pop_front());
      2: void'(qC7.pop_front());
      3: void'(qC35.pop_front());
      4: void'(qP.pop_front());
      default: void'(qN.pop_front());
    endcase
  endfunction

  function automatic bit slotP(input int tr, input int d);
    case (tr)
      0: return d == 0;
      1: return (d % 8) == 0;
      2: return (d % 4) == 0;
      default: return (d % 2) == 0;
    endcase
  endfunction

  function automatic bit slotN(input int tr, input int d);
    case (tr)
      0: return d == 8;
      1: return (d % 8) == 4;
      2: return (d % 4) == 2;
      default: return (d % 2) == 1;
    endcase
  endfunction

  // One 16-cycle divider period starting at cycle base; dropP/dropN name CPU strobes removed by cpu_hold.
  task automatic pushBlock(input int base, input int tr, input int dHi, input int dropP, input int dropN);
    for (int d = 0; d <= dHi; d++) begin
      if ((d % 2) == 0) qC28.push_back(base + d);
      if ((d % 4) == 0) qC14.push_back(base + d);
      if ((d % 8) == 0) qC7.push_back(base + d);
      if (d == 0) qC35.push_back(base + d);
      if (slotP(tr, d) && (base + d) != dropP) qP.push_back(base + d);
      if (slotN(tr, d) && (base + d) != dropN) qN.push_back(base + d);
    end
  endtask

  task automatic pushRst(input int c, input logic v);
    rstEv_t e;
    e.c = c;
    e.v = v;
    qRst.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %0b required %0b", name, cyc, got, want);
    end
  endtask

  task automatic monitorLoop();
    logic [5:0] ceVec;
    logic       expHi;
    logic       expChg;
    logic       prevRst = 1'b1;
    logic       expRst = 1'b1;
    forever begin
      @(negedge clk_sys);
      if (monOn) begin
        ceVec = {ce_cpu_n, ce_cpu_p, ce_3m5, ce_7m, ce_14m, ce_28m};
        for (int s = 0; s < 6; s++) begin
          expHi = (qSize(s) > 0) && (qFront(s) == cyc);
          if (expHi) qPop(s);
          if (expHi || ceVec[s]) checkOutput(names[s], ceVec[s], expHi);
        end
        expChg = 1'b0;
        if (qRst.size() > 0 && qRst[0].c == cyc) begin
          expRst = qRst[0].v;
          void'(qRst.pop_front());
          expChg = 1'b1;
        end
        if (expChg || sys_reset !== prevRst) checkOutput("sys_reset", sys_reset, expRst);
        prevRst = sys_reset;
      end
    end
  endtask

  task automatic waitCyc(input int n);
    do @(negedge clk_sys); while (cyc < n);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_sys_reset"}, sys_reset, 1'b1);
    checkOutput({tag, "_ce_28m"}, ce_28m, 1'b0);
    checkOutput({tag, "_ce_14m"}, ce_14m, 1'b0);
    checkOutput({tag, "_ce_7m"}, ce_7m, 1'b0);
    checkOutput({tag, "_ce_3m5"}, ce_3m5, 1'b0);
    checkOutput({tag, "_ce_cpu_p"}, ce_cpu_p, 1'b0);
    checkOutput({tag, "_ce_cpu_n"}, ce_cpu_n, 1'b0);
  endtask

  // Timeline: lock seen at edge 7, common-zero strobes at cycle 8, so divider phase d = (cycle - 8) mod 16.
  task automatic applyStimulus();
    #1 rst_n = 1'b0;
    for (int b = 0; b < 4; b++) pushBlock(8 + 16 * b, 0, 15, -1, -1);
    pushRst(8 + LW, 1'b0);
    waitCyc(3);
    checkResetState("por");
    waitCyc(5);
    rst_n = 1'b1;

    // Turbo steps issued at divider phase 5; each new rate begins at the next wrap.
    waitCyc(60);
    turbo = 2'd1;
    pushBlock(72, 1, 15, -1, -1);
    waitCyc(76);
    turbo = 2'd2;
    pushBlock(88, 2, 15, -1, -1);
    waitCyc(92);
    turbo = 2'd3;
    pushBlock(104, 3, 15, -1, -1);
    pushBlock(120, 3, 15, 124, 125);
    waitCyc(123);
    cpu_hold = 1'b1;
    waitCyc(124);
    cpu_hold = 1'b0;

    waitCyc(128);
    turbo = 2'd0;
    pushBlock(136, 0, 15, -1, -1);
    pushBlock(152, 0, 15, 152, 160);
    pushBlock(168, 0, 15, -1, -1);
    pushBlock(184, 0, 8, -1, -1);
    waitCyc(145);
    cpu_hold = 1'b1;
    waitCyc(165);
    cpu_hold = 1'b0;

    // Lock dropped while the divider holds 7; relock restarts alignment at cycle 203.
    waitCyc(190);
    pll_locked = 1'b0;
    pushRst(193, 1'b1);
    pushBlock(203, 0, 15, -1, -1);
    pushBlock(219, 0, 15, -1, -1);
    pushBlock(235, 0, 4, -1, -1);
    pushRst(203 + LW, 1'b0);
    waitCyc(200);
    pll_locked = 1'b1;

    waitCyc(239);
    checkOutput("pre_areset_ce_28m", ce_28m, 1'b1);
    #2;
    monOn = 1'b0;
    rst_n = 1'b0;
    #1;
    checkResetState("areset");
    repeat (2) @(negedge clk_sys);
    checkResetState("areset_hold");
  endtask

  initial begin
    fork
      monitorLoop();
    join_none
    applyStimulus();
    for (int s = 0; s < 6; s++) begin
      total++;
      if (qSize(s) != 0) begin
        bad++;
        $display("[TB] FAIL %s leftover: got %0d unseen strobes (first at cycle %0d) required 0",
                 names[s], qSize(s), qFront(s));
      end
    end
    total++;
    if (qRst.size() != 0) begin
      bad++;
      $display("[TB] FAIL sys_reset leftover: got %0d unseen transitions required 0", qRst.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
